// File: rtl/fetch_stage_pkg.sv
// Shared CPU parameter header for the front end: word width, reset PC, NOP encoding
// and the slot type that moves through the IF/ID path.
package fetch_stage_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] DEF_RESET_PC = 32'h1c00_0000;
    // andi r0,r0,0
    localparam logic [WORD-1:0] DEF_NOP_INST = 32'h0340_0000;
    localparam logic [WORD-1:0] INST_STEP    = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [WORD-1:0] pc;
        logic [WORD-1:0] inst;
    } fetch_slot_t;

    function automatic logic [WORD-1:0] align_word(input logic [WORD-1:0] addr);
        return {addr[WORD-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// One-entry skid register holding a fetch response that arrived while IF/ID could not take it.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetch_slot_t in_slot,
    output fetch_slot_t slot
);

    // A push in the same cycle as a pop replaces the drained entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (flush) begin
            slot.valid <= 1'b0;
        end else if (push) begin
            slot <= in_slot;
        end else if (pop) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a 1-cycle
// synchronous instruction memory and fills the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            br_taken,
    input  logic [WORD-1:0] br_target,
    input  logic            id_stall,
    output logic            if_valid,
    output logic [WORD-1:0] if_pc,
    output logic [WORD-1:0] if_inst
);

    logic [WORD-1:0] pc;
    logic [WORD-1:0] req_pc;
    logic            req_v;
    logic            hold;
    logic            issue;
    logic            sk_push;
    logic            sk_pop;
    logic            sk_v;
    fetch_slot_t     rsp_slot;
    fetch_slot_t     sk;

    // Handshake toward decode: if_valid is valid, ~id_stall is ready; an instruction
    // transfers on a cycle with if_valid & ~id_stall, otherwise IF/ID holds its content.
    assign hold      = id_stall & if_valid;
    assign issue     = ~rst & ~br_taken & ~hold;
    assign imem_en   = issue;
    assign imem_addr = pc;

    assign rsp_slot = {req_v, req_pc, imem_rdata};
    assign sk_v     = sk.valid;
    // The response parks in the skid when IF/ID holds or the skid is the older entry.
    assign sk_push  = req_v & ~br_taken & (hold | sk_v);
    assign sk_pop   = sk_v & ~hold & ~br_taken;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .push    (sk_push),
        .pop     (sk_pop),
        .flush   (br_taken),
        .in_slot (rsp_slot),
        .slot    (sk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_v    <= 1'b0;
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
        end else if (br_taken) begin
            pc       <= align_word(br_target);
            req_v    <= 1'b0;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else begin
            req_v <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + INST_STEP;
            end
            if (!hold) begin
                if (sk_v) begin
                    if_valid <= 1'b1;
                    if_pc    <= sk.pc;
                    if_inst  <= sk.inst;
                end else if (req_v) begin
                    if_valid <= 1'b1;
                    if_pc    <= req_pc;
                    if_inst  <= imem_rdata;
                end else begin
                    if_valid <= 1'b0;
                    if_inst  <= NOP_INST;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed timing checks plus an in-order
// delivery scoreboard fed with the expected PC stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] NOP    = 32'h0340_0000;
    localparam logic [31:0] XORK   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .id_stall   (id_stall),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    // Synchronous instruction memory, one-cycle latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ XORK;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 400; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard: each accepted instruction must be the next expected PC.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (dut.sk_push && dut.sk_v && !dut.sk_pop) begin
                failures++;
                $display("FAIL skid_overflow push into full skid at %0t", $time);
            end
            if (if_valid && !id_stall && !br_taken && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra got pc=%h expected none", if_pc);
                end else begin
                    logic [31:0] exp_pc;
                    exp_pc = exp_q.pop_front();
                    checks++;
                    if (if_pc !== exp_pc) begin
                        failures++;
                        $display("FAIL stream_pc got=%h exp=%h", if_pc, exp_pc);
                    end
                    checks++;
                    if (if_inst !== (exp_pc ^ XORK)) begin
                        failures++;
                        $display("FAIL stream_inst got=%h exp=%h", if_inst, exp_pc ^ XORK);
                    end
                    delivered++;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; br_taken = 1'b0; id_stall = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        checks++; if (if_inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", if_inst, NOP); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", imem_en); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
        tick();
        rst = 1'b0;
        load_stream(RST_PC);
        mon_en = 1'b1;
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("FAIL first_issue got en=%b addr=%h exp en=1 addr=%h", imem_en, imem_addr, RST_PC); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL first_bubble1 got=%b exp=0", if_valid); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL first_bubble2 got=%b exp=0", if_valid); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin failures++; $display("FAIL first_out got v=%b pc=%h exp v=1 pc=%h", if_valid, if_pc, RST_PC); end
        tick(); @(negedge clk);
        checks++; if (if_pc !== RST_PC + 32'h4) begin failures++; $display("FAIL second_out got=%h exp=%h", if_pc, RST_PC + 32'h4); end
    endtask

    task automatic test_stall;
        tick();
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'h8) begin failures++; $display("FAIL stall_hold%0d got v=%b pc=%h exp v=1 pc=%h", i, if_valid, if_pc, RST_PC + 32'h8); end
            checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL stall_en%0d got=%b exp=0", i, imem_en); end
            tick();
        end
        id_stall = 1'b0;
        @(negedge clk);
        checks++; if (if_pc !== RST_PC + 32'h8) begin failures++; $display("FAIL release_hold got=%h exp=%h", if_pc, RST_PC + 32'h8); end
        checks++; if (imem_en !== 1'b1 || imem_addr !== RST_PC + 32'h10) begin failures++; $display("FAIL release_issue got en=%b addr=%h exp en=1 addr=%h", imem_en, imem_addr, RST_PC + 32'h10); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'hc) begin failures++; $display("FAIL release_skid got v=%b pc=%h exp v=1 pc=%h", if_valid, if_pc, RST_PC + 32'hc); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'h10) begin failures++; $display("FAIL release_next got v=%b pc=%h exp v=1 pc=%h", if_valid, if_pc, RST_PC + 32'h10); end
    endtask

    task automatic test_branch;
        tick();
        br_taken = 1'b1; br_target = 32'h1c00_0100;
        @(negedge clk);
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL br_en got=%b exp=0", imem_en); end
        tick();
        br_taken = 1'b0;
        load_stream(32'h1c00_0100);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_inst !== NOP) begin failures++; $display("FAIL br_bubble1 got v=%b inst=%h exp v=0 inst=%h", if_valid, if_inst, NOP); end
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h1c00_0100) begin failures++; $display("FAIL br_addr got en=%b addr=%h exp en=1 addr=1c000100", imem_en, imem_addr); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL br_bubble2 got=%b exp=0", if_valid); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0100) begin failures++; $display("FAIL br_target got v=%b pc=%h exp v=1 pc=1c000100", if_valid, if_pc); end
        tick(); @(negedge clk);
    endtask

    task automatic test_branch_stall_skid;
        tick();
        id_stall = 1'b1;
        @(negedge clk);
        checks++; if (if_pc !== 32'h1c00_0108) begin failures++; $display("FAIL bss_pre got=%h exp=1c000108", if_pc); end
        tick();
        br_taken = 1'b1; br_target = 32'h1c00_0200;
        @(negedge clk);
        checks++; if (dut.sk_v !== 1'b1) begin failures++; $display("FAIL bss_skid_full got=%b exp=1", dut.sk_v); end
        tick();
        br_taken = 1'b0; id_stall = 1'b0;
        load_stream(32'h1c00_0200);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h1c00_0200) begin failures++; $display("FAIL bss_flush got v=%b addr=%h exp v=0 addr=1c000200", if_valid, imem_addr); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL bss_bubble2 got=%b exp=0", if_valid); end
        tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0200) begin failures++; $display("FAIL bss_target got v=%b pc=%h exp v=1 pc=1c000200", if_valid, if_pc); end
        tick(); @(negedge clk);
    endtask

    task automatic test_align_wrap;
        tick();
        br_taken = 1'b1; br_target = 32'h1c00_0103;
        tick();
        br_target = 32'hFFFF_FFFC;
        load_stream(32'hFFFF_FFFC);
        @(negedge clk);
        checks++; if (imem_addr !== 32'h1c00_0100) begin failures++; $display("FAIL align_addr got=%h exp=1c000100", imem_addr); end
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got en=%b addr=%h exp en=1 addr=fffffffc", imem_en, imem_addr); end
        tick(); @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero got en=%b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
        tick(); @(negedge clk);
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_out_top got=%h exp=fffffffc", if_pc); end
        tick(); @(negedge clk);
        checks++; if (if_pc !== 32'h0 || if_inst !== XORK) begin failures++; $display("FAIL wrap_out_zero got pc=%h inst=%h exp pc=0 inst=%h", if_pc, if_inst, XORK); end
    endtask

    task automatic test_back_to_back;
        int d0;
        logic [31:0] t;
        d0 = delivered;
        for (int i = 0; i < 300; i++) begin
            tick();
            id_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                t = $urandom();
                br_taken = 1'b1; br_target = t;
                load_stream({t[31:2], 2'b00});
            end else begin
                br_taken = 1'b0;
            end
        end
        tick();
        br_taken = 1'b0; id_stall = 1'b0;
        repeat (4) tick();
        checks++; if (delivered - d0 < 60) begin failures++; $display("FAIL b2b_throughput got=%0d exp>=60", delivered - d0); end
    endtask

    task automatic test_reset_mid;
        tick();
        br_taken = 1'b1; br_target = 32'h1c00_0300;
        load_stream(32'h1c00_0300);
        tick(); br_taken = 1'b0;
        tick();
        tick();
        id_stall = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0300) begin failures++; $display("FAIL rm_pre got v=%b pc=%h exp v=1 pc=1c000300", if_valid, if_pc); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (dut.sk_v !== 1'b1) begin failures++; $display("FAIL rm_skid_full got=%b exp=1", dut.sk_v); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_inst !== NOP || imem_en !== 1'b0) begin failures++; $display("FAIL rm_cleared got v=%b inst=%h en=%b exp v=0 inst=%h en=0", if_valid, if_inst, imem_en, NOP); end
        checks++; if (dut.sk_v !== 1'b0) begin failures++; $display("FAIL rm_skid_empty got=%b exp=0", dut.sk_v); end
        tick();
        rst = 1'b0; id_stall = 1'b0;
        load_stream(RST_PC);
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("FAIL rm_restart got en=%b addr=%h exp en=1 addr=%h", imem_en, imem_addr, RST_PC); end
        tick(); tick(); @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin failures++; $display("FAIL rm_first got v=%b pc=%h exp v=1 pc=%h", if_valid, if_pc, RST_PC); end
        tick(); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_branch_stall_skid();
        test_align_wrap();
        test_back_to_back();
        test_reset_mid();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 32-bit LoongArch pipeline, sitting directly upstream of the instruction decoder. It owns the PC, issues one word-aligned read per cycle to a synchronous instruction memory with one-cycle latency, and presents `{pc, inst, valid}` in the IF/ID pipeline register. Branch redirects from EX flush it; decode-side stalls hold it. A one-entry skid buffer keeps in-flight responses from being lost.

## Interface
- `RESET_PC`, default 32'h1c00_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0340_0000 (`andi r0,r0,0`): value driven on `if_inst` when `if_valid=0`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_en`  out  1  read request this cycle.
- `imem_addr`  out  32  read address, registered PC, bits [1:0] always 00.
- `imem_rdata`  in  32  data for the address requested in the previous cycle.
- `br_taken`  in  1  single-cycle redirect pulse from EX.
- `br_target`  in  32  redirect address; bits [1:0] ignored (treated as 00).
- `id_stall`  in  1  decode cannot accept; hold IF/ID.
- `if_valid`  out  1  IF/ID register holds a real instruction.
- `if_pc`  out  32  PC of `if_inst`.
- `if_inst`  out  32  instruction word to the decoder.

## Operation
- State: `pc` (next address to issue), `req_v`/`req_pc` (request in flight), skid `{sk_v, sk_pc, sk_inst}`, output `{if_valid, if_pc, if_inst}`.
- `imem_en = ~rst & ~br_taken & ~(id_stall & if_valid)`; `imem_addr = pc`. On issue: `req_v<=1`, `req_pc<=pc`, `pc<=pc+4` (mod 2^32; 0xFFFF_FFFC wraps to 0). No issue: `req_v<=0`.
- Output register loads when `~(id_stall & if_valid)`: from the skid if `sk_v`, otherwise from the response (`req_v`, `req_pc`, `imem_rdata`), otherwise a bubble (`if_valid<=0`).
- A response arriving while the output holds, or while the skid supplies the output, is written to the skid. The issue rule bounds the skid at one entry. Writing a full skid is a design error; the bench asserts it never occurs.
- Program order is strictly preserved: skid content before the current response.
- Redirect (`br_taken=1`) takes priority over stall and everything else. It clears `req_v`, `sk_v` and `if_valid`, sets `pc<={br_target[31:2],2'b00}`, and discards the response arriving that cycle.
- `if_inst` reads `NOP_INST` whenever `if_valid=0`, including reset and flush.

## Timing
- Reset values: `pc=RESET_PC`, `req_v=0`, `sk_v=0`, `if_valid=0`, `if_pc=0`, `if_inst=NOP_INST`, `imem_en=0`.
- First cycle after `rst` falls: `imem_en=1`, `imem_addr=RESET_PC`. Two cycles later: `if_valid=1`, `if_pc=RESET_PC`.
- Request-to-IF/ID latency is 2 cycles; throughput is 1 instruction per cycle with no stalls.
- Redirect in cycle t: `if_valid=0` at t+1 and t+2; `imem_addr=target` at t+1; target instruction appears at t+3 (2 bubbles).
- Stall asserted in cycle t with `if_valid=1`: IF/ID holds; `imem_en=0` from t; the t-1 request lands in the skid at t. Release at cycle u: skid moves to output at u+1, issue resumes at u; no instruction is lost or duplicated.
- Stall with `if_valid=0`: ignored, and the bubble is filled.
- `rst` mid-operation: all state returns to reset values at the next edge; in-flight data is discarded.
- `br_taken` and `id_stall` together: redirect wins; IF/ID is cleared.

## Structure
- `RESET_PC`, `NOP_INST` and the `WORD` width belong in the shared CPU parameter header, alongside the decoder constants.
- One sub-module, `fetch_skid_buf`: one-entry `{valid, pc, inst}` register with `push`, `pop` and `flush`.
- PC and issue logic stay in `fetch_stage`.

## Test plan
- Reset release with memory returning `addr^32'hA5A5_A5A5`: IF/ID shows 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles starting 2 cycles after release.
- `id_stall` held 3 cycles while `if_pc=0x1c000008`: output holds 0x1c000008; after release, sequence continues 0x1c00000c, 0x1c000010 with no gap in PCs and no repeats.
- `br_taken` with target 0x1c000100 in cycle t: `if_valid=0` at t+1 and t+2; `if_pc=0x1c000100` at t+3.
- `br_taken`, `id_stall` and skid full in the same cycle: all flushed; the target appears at t+3; nothing from the old path appears after t.
- Target 0x1c000103: `imem_addr=0x1c000100`. PC 0xFFFFFFFC followed by fetch: next `imem_addr=0x00000000`.
- `rst` asserted mid-stream with skid full: next cycle `if_valid=0`, `if_inst=0x03400000`, `imem_en=0`; after release, fetch restarts at 0x1c000000.
